// File: rtl/rib_arbiter.sv
// rib_arbiter: round-robin arbiter for the shared RIB bus.
// Registered one-hot grant, fairness timeout on contended unlocked owners,
// owner bus-lock, and a combinational CPU stall flag.
module rib_arbiter #(
    parameter int unsigned          NUM_M    = 4,
    parameter int unsigned          MAX_HOLD = 16,
    parameter logic [NUM_M-1:0]     CPU_MASK = 4'b0011
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           req_i,
    input  logic [NUM_M-1:0]           lock_i,
    output logic [NUM_M-1:0]           grant_o,
    output logic [$clog2(NUM_M)-1:0]   grant_idx_o,
    output logic                       grant_valid_o,
    output logic                       hold_flag_o,
    output logic                       timeout_o
);

    localparam int unsigned IW = $clog2(NUM_M);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_M-1:0]  grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic [IW-1:0]     search_base;
    logic [NUM_M-1:0]  search_mask;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    int unsigned       cand;

    // Round-robin search: first requester after the base index, owner excluded.
    always_comb begin
        search_base = (state_q == BUSY) ? idx_q : last_q;
        search_mask = req_i & ~grant_q;
        win_found   = 1'b0;
        win_idx     = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= NUM_M; k++) begin
            cand = (int'(search_base) + k) % NUM_M;
            if (!win_found && search_mask[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Next-state logic: grant, release, hold counter and timeout preemption.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = NUM_M'(1) << win_idx;
                    idx_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!req_i[idx_q]) begin
                    last_d = idx_q;
                    cnt_d  = '0;
                    if (win_found) begin
                        grant_d = NUM_M'(1) << win_idx;
                        idx_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                    end
                end else if (win_found) begin
                    if (!lock_i[idx_q]) begin
                        if (cnt_q == CW'(MAX_HOLD - 1)) begin
                            last_d    = idx_q;
                            grant_d   = NUM_M'(1) << win_idx;
                            idx_d     = win_idx;
                            cnt_d     = '0;
                            timeout_d = 1'b1;
                        end else if (cnt_q != CW'(MAX_HOLD)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any grant and points last owner at NUM_M-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            last_q    <= IW'(NUM_M - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = (state_q == BUSY);
    assign timeout_o     = timeout_q;
    assign hold_flag_o   = rst ? 1'b0 : |(req_i & CPU_MASK & ~grant_q);

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed testbench for rib_arbiter with hand-computed expectations.
module tb_rib_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic       grant_valid_o;
    logic       hold_flag_o;
    logic       timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    rib_arbiter #(
        .NUM_M    (4),
        .MAX_HOLD (16),
        .CPU_MASK (4'b0011)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .lock_i        (lock_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .hold_flag_o   (hold_flag_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        req_i  = 4'b1111;
        lock_i = 4'b0000;

        // T1 reset
        tick();
        check_eq("t1_rst_grant", 32'(grant_o), 32'h0);
        check_eq("t1_rst_hold", 32'(hold_flag_o), 32'h0);
        check_eq("t1_rst_valid", 32'(grant_valid_o), 32'h0);
        check_eq("t1_rst_tmo", 32'(timeout_o), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("t1_first_grant", 32'(grant_o), 32'h1);
        check_eq("t1_first_idx", 32'(grant_idx_o), 32'h0);
        check_eq("t1_first_valid", 32'(grant_valid_o), 32'h1);
        check_eq("t1_hold", 32'(hold_flag_o), 32'h1);
        req_i = 4'b0000;
        tick();
        check_eq("t1_idle", 32'(grant_o), 32'h0);
        check_eq("t1_idle_valid", 32'(grant_valid_o), 32'h0);

        // T2 round-robin, last owner = 0
        req_i = 4'b0110;
        tick();
        check_eq("t2_g1", 32'(grant_o), 32'h2);
        check_eq("t2_idx1", 32'(grant_idx_o), 32'h1);
        req_i = 4'b0100;
        tick();
        check_eq("t2_g2", 32'(grant_o), 32'h4);
        check_eq("t2_idx2", 32'(grant_idx_o), 32'h2);
        req_i = 4'b0110;
        tick();
        check_eq("t2_g2_held", 32'(grant_o), 32'h4);
        req_i = 4'b0010;
        tick();
        check_eq("t2_g3", 32'(grant_o), 32'h2);
        req_i = 4'b0000;
        tick();
        check_eq("t2_idle", 32'(grant_o), 32'h0);

        // T3 timeout, last owner = 1
        req_i = 4'b0001;
        tick();
        check_eq("t3_own", 32'(grant_o), 32'h1);
        req_i = 4'b0101;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("t3_hold_grant", 32'(grant_o), 32'h1);
            check_eq("t3_no_tmo", 32'(timeout_o), 32'h0);
        end
        tick();
        check_eq("t3_preempt", 32'(grant_o), 32'h4);
        check_eq("t3_tmo_pulse", 32'(timeout_o), 32'h1);
        tick();
        check_eq("t3_tmo_end", 32'(timeout_o), 32'h0);
        check_eq("t3_keep", 32'(grant_o), 32'h4);
        req_i = 4'b0000;
        tick();
        check_eq("t3_idle", 32'(grant_o), 32'h0);

        // T4 lock, last owner = 2
        req_i  = 4'b0001;
        lock_i = 4'b0001;
        tick();
        check_eq("t4_own", 32'(grant_o), 32'h1);
        req_i = 4'b0101;
        for (int i = 0; i < 40; i++) begin
            tick();
            check_eq("t4_locked_grant", 32'(grant_o), 32'h1);
            check_eq("t4_no_tmo", 32'(timeout_o), 32'h0);
        end
        req_i = 4'b0100;
        tick();
        check_eq("t4_release", 32'(grant_o), 32'h4);
        req_i  = 4'b0000;
        lock_i = 4'b0000;
        tick();
        check_eq("t4_idle", 32'(grant_o), 32'h0);

        // T5 CPU stall, last owner = 2
        req_i = 4'b0100;
        tick();
        check_eq("t5_dma_own", 32'(grant_o), 32'h4);
        check_eq("t5_no_stall", 32'(hold_flag_o), 32'h0);
        req_i = 4'b0110;
        #1;
        check_eq("t5_stall", 32'(hold_flag_o), 32'h1);
        req_i = 4'b0010;
        tick();
        check_eq("t5_cpu_grant", 32'(grant_o), 32'h2);
        check_eq("t5_stall_clear", 32'(hold_flag_o), 32'h0);
        req_i = 4'b0000;
        tick();
        check_eq("t5_idle", 32'(grant_o), 32'h0);

        // T6 async reset mid-grant, last owner = 1
        req_i = 4'b1000;
        tick();
        check_eq("t6_m3_own", 32'(grant_o), 32'h8);
        check_eq("t6_m3_idx", 32'(grant_idx_o), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async_grant", 32'(grant_o), 32'h0);
        check_eq("t6_async_valid", 32'(grant_valid_o), 32'h0);
        check_eq("t6_async_idx", 32'(grant_idx_o), 32'h0);
        req_i = 4'b1111;
        tick();
        check_eq("t6_rst_hold", 32'(hold_flag_o), 32'h0);
        rst = 1'b0;
        tick();
        check_eq("t6_m0_first", 32'(grant_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
